// File: rtl/shift_left_seq.sv
// Sequential 32-bit left shifter/rotator: one power-of-two stage (16,8,4,2,1) per clock.
// Latency: start accepted in cycle 0, busy cycles 1..5, done pulse with result in cycle 6.
// Backpressure: start is taken only while ready (IDLE/DONE); starts during SHIFT are dropped.
module shift_left_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [4:0]       shamt,
  input  logic             rot,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [4:0]       amt;
  logic             mode;
  logic [2:0]       step;
  logic             accept;

  // A new operation is taken whenever the unit is ready, including the DONE cycle.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // State register; reset wins over a simultaneous start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status decode; outputs depend on registered state only.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (step == 3'd0) state_nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Current stage result: shift by 2^step, fill with zeros or the bits leaving the MSB end.
  always_comb begin
    shifted = work;
    case (step)
      3'd4: shifted = mode ? {work[15:0], work[31:16]} : {work[15:0], 16'h0000};
      3'd3: shifted = mode ? {work[23:0], work[31:24]} : {work[23:0], 8'h00};
      3'd2: shifted = mode ? {work[27:0], work[31:28]} : {work[27:0], 4'h0};
      3'd1: shifted = mode ? {work[29:0], work[31:30]} : {work[29:0], 2'b00};
      3'd0: shifted = mode ? {work[30:0], work[31]}    : {work[30:0], 1'b0};
      default: shifted = work;
    endcase
  end

  // Working datapath: load on accept, then apply one stage per SHIFT cycle from 16 down to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work <= '0;
      amt  <= '0;
      mode <= 1'b0;
      step <= 3'd0;
    end else if (accept) begin
      work <= in;
      amt  <= shamt;
      mode <= rot;
      step <= 3'd4;
    end else if (state == SHIFT) begin
      if (amt[step]) work <= shifted;
      if (step != 3'd0) step <= step - 3'd1;
    end
  end

  // The result register is visible at all times; it is meaningful from done until the next start.
  assign out = work;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed scenarios plus randomized operations.
// Reference results come from plain 64-bit arithmetic on the operand, not from stage logic.
// Cycle numbering: the edge that accepts start ends cycle 0; outputs are sampled on negedges.
module tb_shift_left_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_in;
  logic [4:0]  op_shamt;
  logic        op_rot;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int checks;
  int errors;

  shift_left_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (op_in),
    .shamt (op_shamt),
    .rot   (op_rot),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: logical shift keeps the low 32 bits of x<<k; rotate takes the window of {x,x}.
  function automatic logic [31:0] ref_model(input logic [31:0] x, input int k, input logic r);
    logic [63:0] d;
    if (r) begin
      d = {x, x};
      d = d >> (32 - k);
      return d[31:0];
    end
    d = {32'h0, x} << k;
    return d[31:0];
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts negedges after acceptance.
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic r,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    op_in = a; op_shamt = s; op_rot = r; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    res = 'x;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) begin
        res = out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_in = '0; op_shamt = '0; op_rot = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want %h", out, 32'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    op_in = 32'h0000_0001; op_shamt = 5'd31; op_rot = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL lat_busy cycle %0d got busy=%b ready=%b done=%b want 1 0 0", c, busy, ready, done);
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL lat_done cycle 6 got done=%b ready=%b busy=%b want 1 1 0", done, ready, busy);
    end
    checks++; if (out !== 32'h8000_0000) begin errors++; $display("FAIL lat_out got %h want %h", out, 32'h8000_0000); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL lat_after got done=%b ready=%b want 0 1", done, ready);
    end
  endtask

  task automatic test_modes();
    logic [31:0] a [4];
    logic [4:0]  s [4];
    logic        r [4];
    logic [31:0] want [4];
    logic [31:0] res;
    int lat;
    a[0] = 32'hF000_000F; s[0] = 5'd4; r[0] = 1'b0; want[0] = 32'h0000_00F0;
    a[1] = 32'hF000_000F; s[1] = 5'd4; r[1] = 1'b1; want[1] = 32'h0000_00FF;
    a[2] = 32'hDEAD_BEEF; s[2] = 5'd0; r[2] = 1'b0; want[2] = 32'hDEAD_BEEF;
    a[3] = 32'hDEAD_BEEF; s[3] = 5'd0; r[3] = 1'b1; want[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      run_op(a[i], s[i], r[i], res, lat);
      checks++; if (res !== want[i]) begin errors++; $display("FAIL modes_out case %0d got %h want %h", i, res, want[i]); end
      checks++; if (lat != 6) begin errors++; $display("FAIL modes_lat case %0d got %0d want 6", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op_in = 32'h1; op_shamt = 5'd1; op_rot = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        op_in = 32'hFFFF_FFFF; op_shamt = 5'd31; op_rot = 1'b1; start = 1'b1;
      end
      if (c == 3) start = 1'b0;
    end
    checks++; if (done !== 1'b1 || out !== 32'h2) begin
      errors++; $display("FAIL b2b_first got done=%b out=%h want 1 %h", done, out, 32'h2);
    end
    op_in = 32'h3; op_shamt = 5'd8; op_rot = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 7; c <= 11; c++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL b2b_busy cycle %0d got done=%b busy=%b want 0 1", c, done, busy);
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b1 || out !== 32'h300) begin
      errors++; $display("FAIL b2b_second got done=%b out=%h want 1 %h", done, out, 32'h300);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    logic [31:0] res;
    int lat;
    @(negedge clk);
    op_in = 32'h1234_5678; op_shamt = 5'd12; op_rot = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL abort_state got out=%h done=%b busy=%b ready=%b want 0 0 0 1", out, done, busy, ready);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_nodone got %0d pulses want 0", seen); end
    run_op(32'h1234_5678, 5'd12, 1'b1, res, lat);
    checks++; if (res !== 32'h4567_8123 || lat != 6) begin
      errors++; $display("FAIL abort_fresh got out=%h lat=%0d want %h 6", res, lat, 32'h4567_8123);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [4:0]  s;
    logic        r;
    logic [31:0] res;
    logic [31:0] want;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      s = 5'($urandom_range(31, 0));
      r = 1'($urandom_range(1, 0));
      want = ref_model(a, int'(s), r);
      run_op(a, s, r, res, lat);
      checks++; if (res !== want || lat != 6) begin
        errors++; $display("FAIL rand_op %0d in=%h sh=%0d rot=%b got out=%h lat=%0d want %h 6", n, a, s, r, res, lat, want);
      end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rand_pulse %0d got done=%b want 0", n, done); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
